// File: rtl/slos_ctrl_pkg.sv
// Shared types and default constants for the SLOS receive training controller.
package slos_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S1_HUNT = 3'd1,
    REARM   = 3'd2,
    S2_HUNT = 3'd3,
    DONE    = 3'd4,
    FAIL    = 3'd5
  } state_e;

  localparam int unsigned SLOS1_CNT_DEF      = 2;
  localparam int unsigned SLOS2_CNT_DEF      = 2;
  localparam int unsigned GAP_LIMIT_DEF      = 4200;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;

  // Bits needed to hold 0..limit, never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/slos_sat_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module slos_sat_counter
  import slos_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned WIDTH = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WIDTH-1:0] r_count;
  logic             w_tc;

  assign w_tc = (r_count == WIDTH'(LIMIT));
  assign o_tc = w_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/slos_rx_ctrl.sv
// SLOS1/SLOS2 receive training sequencer. Optional hunt timeout and FAIL state
// are built only when SLOS_RX_CTRL_TIMEOUT_EN is defined.
module slos_rx_ctrl
  import slos_ctrl_pkg::*;
#(
  parameter int unsigned SLOS1_CNT      = SLOS1_CNT_DEF,
  parameter int unsigned SLOS2_CNT      = SLOS2_CNT_DEF,
  parameter int unsigned GAP_LIMIT      = GAP_LIMIT_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic slos_rec,
  output logic rx_enable,
  output logic slos1_slos2,
  output logic slos1_done,
  output logic slos2_done,
  output logic timeout,
  output logic busy
);

  localparam int unsigned DET_MAX = (SLOS1_CNT > SLOS2_CNT) ? SLOS1_CNT : SLOS2_CNT;
  localparam int unsigned DW      = cnt_width(DET_MAX);

  state_e          r_state;
  logic [DW-1:0]   r_det;
  logic [DW-1:0]   w_det_next;
  logic [DW-1:0]   w_target;
  logic            r_rx_en, r_sel, r_d1, r_d2, r_to, r_busy;
  logic            w_hunt, w_gap_tc, w_gap_exp, w_goal, w_to_exp;

  assign w_hunt    = (r_state == S1_HUNT) || (r_state == S2_HUNT);
  assign w_target  = (r_state == S2_HUNT) ? DW'(SLOS2_CNT) : DW'(SLOS1_CNT);
  assign w_gap_exp = w_hunt && (r_det != '0) && w_gap_tc;

  // Gap counter only runs while a detection run is open (det_cnt non-zero).
  slos_sat_counter #(
    .LIMIT(GAP_LIMIT)
  ) u_gap_cnt (
    .clk  (clk),
    .reset(reset),
    .i_clr(!w_hunt || slos_rec || (r_det == '0) || abort),
    .i_en (w_hunt),
    .o_tc (w_gap_tc)
  );

`ifdef SLOS_RX_CTRL_TIMEOUT_EN
  // Terminal count lands on the TIMEOUT_CYCLES-th hunt cycle.
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  logic w_to_tc;

  slos_sat_counter #(
    .LIMIT(TO_LIMIT)
  ) u_to_cnt (
    .clk  (clk),
    .reset(reset),
    .i_clr(!w_hunt || abort),
    .i_en (w_hunt),
    .o_tc (w_to_tc)
  );

  assign w_to_exp = w_hunt && w_to_tc;
`else
  assign w_to_exp = 1'b0;
`endif

  // A pulse on the gap-expiry cycle opens a fresh run instead of extending the old one.
  always_comb begin
    w_det_next = r_det;
    if (slos_rec) begin
      if (w_gap_exp)              w_det_next = DW'(1);
      else if (r_det != w_target) w_det_next = r_det + 1'b1;
    end else if (w_gap_exp) begin
      w_det_next = '0;
    end
  end

  assign w_goal = slos_rec && (w_det_next == w_target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || abort) begin
      r_state <= IDLE;
      r_det   <= '0;
      r_rx_en <= 1'b0;
      r_sel   <= 1'b0;
      r_d1    <= 1'b0;
      r_d2    <= 1'b0;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_det <= '0;
          if (start) begin
            r_state <= S1_HUNT;
            r_rx_en <= 1'b1;
            r_sel   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S1_HUNT, S2_HUNT: begin
          r_det <= w_det_next;
          if (w_goal) begin
            r_rx_en <= 1'b0;
            r_det   <= '0;
            if (r_state == S1_HUNT) begin
              r_state <= REARM;
              r_d1    <= 1'b1;
              r_sel   <= 1'b1;
            end else begin
              r_state <= DONE;
              r_d2    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else if (w_to_exp) begin
            r_state <= FAIL;
            r_to    <= 1'b1;
            r_rx_en <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        REARM: begin
          r_state <= S2_HUNT;
          r_rx_en <= 1'b1;
          r_det   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rx_enable   = r_rx_en;
  assign slos1_slos2 = r_sel;
  assign slos1_done  = r_d1;
  assign slos2_done  = r_d2;
  assign timeout     = r_to;
  assign busy        = r_busy;

endmodule

// File: tb/tb_slos_rx_ctrl.sv
// Randomised bench for slos_rx_ctrl against a pulse-distance reference model.
module tb_slos_rx_ctrl;

  localparam int unsigned S1N = 2;
  localparam int unsigned S2N = 3;
  localparam int unsigned GAP = 20;
  localparam int unsigned TO  = 100;
`ifdef SLOS_RX_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int PI = 0, PS1 = 1, PRA = 2, PS2 = 3, PDN = 4, PFL = 5;

  logic clk = 1'b0;
  logic reset, start, abort, slos_rec;
  logic rx_enable, slos1_slos2, slos1_done, slos2_done, timeout, busy;

  slos_rx_ctrl #(
    .SLOS1_CNT     (S1N),
    .SLOS2_CNT     (S2N),
    .GAP_LIMIT     (GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .slos_rec   (slos_rec),
    .rx_enable  (rx_enable),
    .slos1_slos2(slos1_slos2),
    .slos1_done (slos1_done),
    .slos2_done (slos2_done),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_phase, m_det, m_last, m_hunt, m_cyc;
  bit m_d1, m_d2, m_to;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PI;
    m_det   = 0;
    m_d1    = 1'b0;
    m_d2    = 1'b0;
    m_to    = 1'b0;
  endtask

  // One clock edge: consecutive pulses are those no more than GAP cycles apart.
  task automatic model_step(input bit s, input bit a, input bit r);
    int tgt;
    m_cyc++;
    if (a) begin
      model_reset();
      return;
    end
    case (m_phase)
      PI: if (s) begin
        m_phase = PS1;
        m_det   = 0;
        m_hunt  = 0;
      end
      PS1, PS2: begin
        m_hunt++;
        tgt = (m_phase == PS1) ? S1N : S2N;
        if (r) begin
          m_det  = (m_det > 0 && (m_cyc - m_last) <= GAP) ? m_det + 1 : 1;
          m_last = m_cyc;
        end
        if (r && m_det == tgt) begin
          if (m_phase == PS1) begin
            m_phase = PRA;
            m_d1    = 1'b1;
          end else begin
            m_phase = PDN;
            m_d2    = 1'b1;
          end
        end else if (TO_EN && m_hunt == TO) begin
          m_phase = PFL;
          m_to    = 1'b1;
        end
      end
      PRA: begin
        m_phase = PS2;
        m_det   = 0;
        m_hunt  = 0;
      end
      default: ;
    endcase
  endtask

  task automatic compare(input string tag);
    logic [7:0] exp;
    exp = {3'b000, (m_phase == PS1 || m_phase == PS2),
           (m_phase >= PS1 && m_phase <= PS2), m_d1, m_d2, m_to};
    check(tag, {3'b000, rx_enable, busy, slos1_done, slos2_done, timeout}, exp);
    if (m_phase <= PS2)
      check("sel", {7'd0, slos1_slos2}, {7'd0, (m_phase == PRA || m_phase == PS2)});
  endtask

  task automatic cycle(input bit s, input bit a, input bit r);
    @(negedge clk);
    start    = s;
    abort    = a;
    slos_rec = r;
    model_step(s, a, r);
    @(posedge clk);
    #1;
    compare("outs");
  endtask

  // Reset pulse wholly between two rising edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    slos_rec = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_rst", {2'b00, rx_enable, slos1_slos2, busy, slos1_done, slos2_done, timeout},
          8'h00);
    reset = 1'b0;
    model_reset();
    model_step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    compare("post_rst");
  endtask

  task automatic pulse_after(input int n);
    for (int k = 1; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int rate, len, abort_at, rst_at;
    bit r;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    slos_rec = 1'b0;
    m_cyc    = 0;
    m_last   = 0;
    m_hunt   = 0;
    model_reset();
    #12;
    check("reset_outs", {2'b00, rx_enable, slos1_slos2, busy, slos1_done, slos2_done, timeout},
          8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Gap boundary: GAP+1 apart restarts the run, exactly GAP apart extends it.
    cycle(1'b1, 1'b0, 1'b0);
    pulse_after(3);
    pulse_after(GAP + 1);
    pulse_after(GAP);
    cycle(1'b0, 1'b0, 1'b0);
    pulse_after(GAP + 2);
    pulse_after(GAP);
    pulse_after(GAP + 1);
    pulse_after(GAP);
    pulse_after(GAP);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0);

    // Abort coincident with the final SLOS2 pulse.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    pulse_after(2);
    pulse_after(2);
    cycle(1'b0, 1'b0, 1'b0);
    pulse_after(2);
    pulse_after(2);
    for (int k = 0; k < 1; k++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    for (int ep = 0; ep < 80; ep++) begin
      rate     = (ep % 4 == 0) ? 0 : int'($urandom_range(4, 40));
      len      = int'($urandom_range(150, 350));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      rst_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < len; i++) begin
        if (i == rst_at) begin
          async_reset();
        end else begin
          r = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
          cycle((i == 0) || ($urandom_range(0, 15) == 0), (i == abort_at), r);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
